// File: rtl/argmax_layer.sv
// argmax_layer: streams signed class scores per frame and reports the index and
// value of the largest one, with a frame-length error flag and a frame counter.
module argmax_layer #(
  parameter int DW          = 16,
  parameter int NUM_CLASS   = 10,
  parameter int IDX_W       = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   blob_din,
  input  logic                   blob_din_en,
  input  logic                   blob_din_eop,
  output logic                   blob_din_rdy,
  output logic [IDX_W-1:0]       class_idx,
  output logic signed [DW-1:0]   class_score,
  output logic                   class_valid,
  output logic                   class_err,
  input  logic                   class_ack,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // Word counter is one bit wider than the index so it can hold NUM_CLASS.
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic signed [DW-1:0]   r_max, w_max_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_rdy, w_rdy_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [IDX_W-1:0]       r_res_idx, w_res_idx_nxt;
  logic signed [DW-1:0]   r_res_score, w_res_score_nxt;
  logic                   r_res_err, w_res_err_nxt;
  logic [FRAME_CNT_W-1:0] r_fcnt, w_fcnt_nxt;
  logic                   w_accept;
  logic                   w_done;

  assign blob_din_rdy = r_rdy;
  assign class_valid  = r_valid;
  assign class_idx    = r_res_idx;
  assign class_score  = r_res_score;
  assign class_err    = r_res_err;
  assign frame_cnt    = r_fcnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, running argmax and result capture.
  always_comb begin
    w_state_nxt     = r_state;
    w_max_nxt       = r_max;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;
    w_rdy_nxt       = r_rdy;
    w_valid_nxt     = r_valid;
    w_res_idx_nxt   = r_res_idx;
    w_res_score_nxt = r_res_score;
    w_res_err_nxt   = r_res_err;
    w_fcnt_nxt      = r_fcnt;
    w_done          = 1'b0;
    w_accept        = blob_din_en && r_rdy;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_max_nxt = blob_din;
          w_idx_nxt = '0;
          w_cnt_nxt = CNT_W'(1);
          w_err_nxt = 1'b0;
          if (blob_din_eop) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (w_accept) begin
          if (r_cnt < CNT_W'(NUM_CLASS)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            // Strictly greater keeps the lowest index on ties.
            if (blob_din > r_max) begin
              w_max_nxt = blob_din;
              w_idx_nxt = IDX_W'(r_cnt);
            end
          end else begin
            // Surplus words are not compared; count stays saturated.
            w_err_nxt = 1'b1;
          end
          w_done = blob_din_eop;
        end
      end
      S_HOLD: begin
        if (class_ack) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_rdy_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rdy_nxt   = 1'b1;
        w_valid_nxt = 1'b0;
      end
    endcase

    // End of frame: publish the result and block upstream until acknowledged.
    if (w_done) begin
      w_state_nxt     = S_HOLD;
      w_rdy_nxt       = 1'b0;
      w_valid_nxt     = 1'b1;
      w_res_idx_nxt   = w_idx_nxt;
      w_res_score_nxt = w_max_nxt;
      w_res_err_nxt   = w_err_nxt || (w_cnt_nxt != CNT_W'(NUM_CLASS));
      w_fcnt_nxt      = r_fcnt + FRAME_CNT_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rdy       <= 1'b1;
      r_valid     <= 1'b0;
      r_res_idx   <= '0;
      r_res_score <= '0;
      r_res_err   <= 1'b0;
      r_fcnt      <= '0;
    end else begin
      r_max       <= w_max_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
      r_rdy       <= w_rdy_nxt;
      r_valid     <= w_valid_nxt;
      r_res_idx   <= w_res_idx_nxt;
      r_res_score <= w_res_score_nxt;
      r_res_err   <= w_res_err_nxt;
      r_fcnt      <= w_fcnt_nxt;
    end
  end

endmodule
